sram_frame_writer: RTL and testbench

- Write-side engine for the single-port BSRAM frame buffer whose read side feeds the HDMI pixel pipeline (15-bit word address, 6-bit RGB222 word).
- Accepts a valid/ready pixel stream with start-of-frame marking and writes one frame linearly from BASE_ADDR.
- Also performs a hardware fill that writes one colour over the whole frame.
- Yields the port to the display reader whenever the reader announces it.

---
 rtl/sram_frame_writer.sv | 139 +++++++++++++
 tb/tb_sram_frame_writer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_frame_writer.sv
// Write-side engine for the single-port frame buffer: streams one frame or fills it with a colour,
// yielding the port to the display reader whenever sramBusy is raised.
module sram_frame_writer #(
  parameter int ADDR_WIDTH   = 15,
  parameter int DATA_WIDTH   = 6,
  parameter int FRAME_PIXELS = 19200,
  parameter int BASE_ADDR    = 0
) (
  input  logic                  sysCLK,
  input  logic                  sysRESETn,
  input  logic                  pixelValid,
  output logic                  pixelReady,
  input  logic [DATA_WIDTH-1:0] pixelData,
  input  logic                  pixelSof,
  input  logic                  fillStart,
  input  logic [DATA_WIDTH-1:0] fillColor,
  input  logic                  sramBusy,
  input  logic                  errClear,
  output logic                  sramWrEn,
  output logic [ADDR_WIDTH-1:0] sramWrAddress,
  output logic [DATA_WIDTH-1:0] sramWrData,
  output logic                  frameDone,
  output logic                  writerBusy,
  output logic                  syncError
);

  typedef enum logic [1:0] {IDLE, STREAM, FILL} state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(FRAME_PIXELS - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  busy_q;
  logic                  err_q, err_d;
  logic                  accept;
  logic                  err_set;
  logic [ADDR_WIDTH-1:0] idx;

  // Reset gates ready so nothing is accepted while the block is held in reset.
  assign pixelReady = sysRESETn && !sramBusy &&
                      ((state_q == IDLE) ? !fillStart : (state_q == STREAM));
  assign accept     = pixelValid && pixelReady;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    fill_d  = fill_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_set = 1'b0;
    idx     = count_q;

    case (state_q)
      IDLE: begin
        if (fillStart) begin
          fill_d  = fillColor;
          count_d = '0;
          state_d = FILL;
        end else if (accept) begin
          if (pixelSof) begin
            wr_en_d = 1'b1;
            idx     = '0;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      STREAM: begin
        if (accept) begin
          wr_en_d = 1'b1;
          // An early start-of-frame restarts the frame and flags the framing slip.
          if (pixelSof) begin
            idx     = '0;
            err_set = 1'b1;
          end
        end
      end
      FILL: begin
        if (!sramBusy) wr_en_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (wr_en_d) begin
      addr_d = BASE + idx;
      data_d = (state_q == FILL) ? fill_q : pixelData;
      if (idx == LAST) begin
        done_d  = 1'b1;
        count_d = '0;
        state_d = IDLE;
      end else begin
        count_d = idx + ADDR_WIDTH'(1);
        state_d = (state_q == FILL) ? FILL : STREAM;
      end
    end

    err_d = err_set | (err_q & ~errClear);
  end

  always_ff @(posedge sysCLK or negedge sysRESETn) begin
    if (!sysRESETn) begin
      state_q <= IDLE;
      count_q <= '0;
      fill_q  <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      fill_q  <= fill_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      busy_q  <= (state_q != IDLE);
      err_q   <= err_d;
    end
  end

  assign sramWrEn      = wr_en_q;
  assign sramWrAddress = addr_q;
  assign sramWrData    = data_q;
  assign frameDone     = done_q;
  assign writerBusy    = busy_q;
  assign syncError     = err_q;

endmodule

// File: tb/tb_sram_frame_writer.sv
// Directed bench for sram_frame_writer: a small reference model pushes expected writes to a
// scoreboard as stimulus is driven; a negedge monitor pops and compares each DUT write.
module tb_sram_frame_writer;

  localparam int AW   = 15;
  localparam int DW   = 6;
  localparam int NPIX = 8;
  localparam int BASE = 'h100;

  logic          clk = 1'b0;
  logic          sysRESETn;
  logic          pixelValid, pixelSof, fillStart, sramBusy, errClear;
  logic [DW-1:0] pixelData, fillColor;
  logic          pixelReady, sramWrEn, frameDone, writerBusy, syncError;
  logic [AW-1:0] sramWrAddress;
  logic [DW-1:0] sramWrData;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          done;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   wr_cnt = 0;
  int   done_cnt = 0;

  // Reference model state: 0 idle, 1 stream, 2 fill.
  int   m_state = 0;
  int   m_cnt = 0;
  int   m_fcnt = 0;
  logic m_err = 1'b0;

  sram_frame_writer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_PIXELS(NPIX), .BASE_ADDR(BASE)
  ) dut (
    .sysCLK(clk), .sysRESETn(sysRESETn),
    .pixelValid(pixelValid), .pixelReady(pixelReady), .pixelData(pixelData),
    .pixelSof(pixelSof), .fillStart(fillStart), .fillColor(fillColor),
    .sramBusy(sramBusy), .errClear(errClear),
    .sramWrEn(sramWrEn), .sramWrAddress(sramWrAddress), .sramWrData(sramWrData),
    .frameDone(frameDone), .writerBusy(writerBusy), .syncError(syncError)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    chk("frameDone_without_wrEn", 32'(frameDone & ~sramWrEn), 32'd0);
    if (frameDone) done_cnt++;
    if (sramWrEn) begin
      wr_cnt++;
      chk("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_addr", 32'(sramWrAddress), 32'(e.a));
        chk("wr_data", 32'(sramWrData), 32'(e.d));
        chk("wr_frameDone", 32'(frameDone), 32'(e.done));
      end
    end
  end

  task automatic push_beat(input int idx, input logic [DW-1:0] d);
    sb.push_back('{AW'(BASE + idx), d, (idx == NPIX - 1)});
    if (idx == NPIX - 1) begin
      m_state = 0;
      m_cnt   = 0;
    end else begin
      m_state = 1;
      m_cnt   = idx + 1;
    end
  endtask

  // One clock cycle of stimulus, entered and left at posedge+1.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic sof, input logic busy,
                     input logic fs, input logic [DW-1:0] fc, input logic ec);
    logic exp_rdy, acc, set, prev_busy;
    pixelValid = v; pixelData = d; pixelSof = sof; sramBusy = busy;
    fillStart = fs; fillColor = fc; errClear = ec;
    #1;
    exp_rdy = !busy && ((m_state == 0) ? !fs : (m_state == 1));
    chk("pixelReady", 32'(pixelReady), 32'(exp_rdy));
    prev_busy = (m_state != 0);
    acc = v && exp_rdy;
    set = 1'b0;
    case (m_state)
      0: begin
        if (fs) begin
          m_state = 2;
          m_fcnt  = 0;
          for (int i = 0; i < NPIX; i++) sb.push_back('{AW'(BASE + i), fc, (i == NPIX - 1)});
        end else if (acc) begin
          if (sof) push_beat(0, d);
          else set = 1'b1;
        end
      end
      1: begin
        if (acc) begin
          if (sof) set = 1'b1;
          push_beat(sof ? 0 : m_cnt, d);
        end
      end
      default: begin
        if (!busy) begin
          m_fcnt++;
          if (m_fcnt == NPIX) m_state = 0;
        end
      end
    endcase
    m_err = set ? 1'b1 : (ec ? 1'b0 : m_err);
    @(posedge clk); #1;
    chk("syncError", 32'(syncError), 32'(m_err));
    chk("writerBusy", 32'(writerBusy), 32'(prev_busy));
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic sof);
    cyc(1'b1, d, sof, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic idle(input logic busy, input logic ec);
    cyc(1'b0, '0, 1'b0, busy, 1'b0, '0, ec);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wrEn"}, 32'(sramWrEn), 32'd0);
    chk({tag, "_addr"}, 32'(sramWrAddress), 32'd0);
    chk({tag, "_data"}, 32'(sramWrData), 32'd0);
    chk({tag, "_frameDone"}, 32'(frameDone), 32'd0);
    chk({tag, "_writerBusy"}, 32'(writerBusy), 32'd0);
    chk({tag, "_syncError"}, 32'(syncError), 32'd0);
    chk({tag, "_pixelReady"}, 32'(pixelReady), 32'd0);
  endtask

  initial begin
    int d0, w0;
    sysRESETn = 1'b0;
    pixelValid = 1'b0; pixelData = '0; pixelSof = 1'b0; fillStart = 1'b0;
    fillColor = '0; sramBusy = 1'b0; errClear = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) sysRESETn = 1'b1;
    @(posedge clk); #1;

    // Full frame, back-to-back beats.
    d0 = done_cnt;
    beat(6'h01, 1'b1);
    for (int i = 2; i <= NPIX; i++) beat(6'(i), 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    chk("stream_done_count", 32'(done_cnt - d0), 32'd1);

    // Reader steals the port for 3 cycles mid-frame.
    beat(6'h11, 1'b1);
    beat(6'h12, 1'b0);
    beat(6'h13, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b1, 6'h14, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 4; i <= NPIX; i++) beat(6'(8'h10 + i), 1'b0);
    idle(1'b0, 1'b0);

    // Fill wins over a simultaneous sof beat; stretched by two busy cycles.
    d0 = done_cnt;
    cyc(1'b1, 6'h15, 1'b1, 1'b0, 1'b1, 6'h2A, 1'b0);
    for (int k = 0; k < 20 && m_state == 2; k++)
      cyc(1'b1, 6'h16, 1'b1, (k == 2 || k == 3), 1'b0, '0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    chk("fill_done_count", 32'(done_cnt - d0), 32'd1);

    // Framing errors: beat without sof in idle, clear, then early sof with a coincident clear.
    beat(6'h05, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b1);
    beat(6'h21, 1'b1);
    beat(6'h22, 1'b0);
    beat(6'h23, 1'b0);
    cyc(1'b1, 6'h09, 1'b1, 1'b0, 1'b0, '0, 1'b1);
    for (int i = 1; i < NPIX; i++) beat(6'(8'h30 + i), 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b1);

    // Reset after 5 of 8 fill writes.
    d0 = done_cnt;
    w0 = wr_cnt;
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 6'h15, 1'b0);
    for (int k = 0; k < 5; k++) idle(1'b0, 1'b0);
    @(negedge clk); #1;
    chk("fill_writes_before_reset", 32'(wr_cnt - w0), 32'd5);
    sysRESETn = 1'b0;
    #1;
    check_reset_outputs("midfill_reset");
    sb.delete();
    m_state = 0; m_cnt = 0; m_fcnt = 0; m_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) sysRESETn = 1'b1;
    @(posedge clk); #1;
    chk("no_frameDone_after_reset", 32'(done_cnt - d0), 32'd0);
    beat(6'h3F, 1'b1);
    for (int i = 2; i <= NPIX; i++) beat(6'(8'h38 + i), 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
